// File: rtl/io_port_unit_pkg.sv
// Shared constants for the processor I/O port unit: data width, default FIFO depth
// and the bit positions of the two interrupt lines.
package io_port_unit_pkg;
    localparam int unsigned inPortWidth     = 16;
    localparam int unsigned DEFAULT_DEPTH   = 4;
    localparam int unsigned IRQ_IN_ARRIVAL  = 0;
    localparam int unsigned IRQ_OUT_OVERRUN = 1;
endpackage

// File: rtl/io_fifo.sv
// Circular FIFO with registered pointers and count; the head word is read combinationally.
// A push into a full FIFO is only accepted when a pop happens in the same cycle.
module io_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         headData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic [CW-1:0]    cnt;
    logic             doPush;
    logic             doPop;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign headData = mem[rdPtr];

    always_comb begin
        doPop  = pop && !empty && !reset;
        doPush = push && (!full || doPop) && !reset;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            case ({doPush, doPop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is deliberately left unreset; consumers gate the head with empty.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end
endmodule

// File: rtl/io_port_unit.sv
// Processor I/O port peripheral: an output FIFO drained by a device, an input FIFO
// filled by a device, and two pulse interrupts for input arrival and output overrun.
module io_port_unit
    import io_port_unit_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = inPortWidth
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       outPortData,
    input  logic                   outSignalEn,
    input  logic                   inPortRead,
    output logic [WIDTH-1:0]       inPortData,
    output logic [1:0]             interruptSignal,
    output logic [WIDTH-1:0]       devOutData,
    output logic                   devOutValid,
    input  logic                   devOutReady,
    input  logic [WIDTH-1:0]       devInData,
    input  logic                   devInValid,
    output logic                   devInReady,
    output logic [$clog2(DEPTH):0] outCount,
    output logic [$clog2(DEPTH):0] inCount
);
    logic [WIDTH-1:0] outHead;
    logic [WIDTH-1:0] inHead;
    logic             outFull;
    logic             outEmpty;
    logic             inFull;
    logic             inEmpty;
    logic             outPush;
    logic             outPop;
    logic             outDrop;
    logic             inPush;
    logic             inPop;
    logic             inArrival;
    logic [1:0]       irqNext;
    logic [1:0]       irqReg;

    // Push/pop qualification for both paths.
    always_comb begin
        outPop    = !outEmpty && devOutReady;
        outPush   = outSignalEn && (!outFull || outPop);
        outDrop   = outSignalEn && outFull && !outPop;
        inPush    = devInValid && !inFull && !reset;
        inPop     = inPortRead && !inEmpty;
        inArrival = inPush && inEmpty;
    end

    always_comb begin
        irqNext = '0;
        irqNext[1'(IRQ_IN_ARRIVAL)]  = inArrival;
        irqNext[1'(IRQ_OUT_OVERRUN)] = outDrop;
    end

    always_ff @(posedge clk) begin
        if (reset) irqReg <= '0;
        else       irqReg <= irqNext;
    end

    io_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) uOutFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (outPush),
        .pushData (outPortData),
        .pop      (outPop),
        .headData (outHead),
        .full     (outFull),
        .empty    (outEmpty),
        .count    (outCount)
    );

    io_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) uInFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (inPush),
        .pushData (devInData),
        .pop      (inPop),
        .headData (inHead),
        .full     (inFull),
        .empty    (inEmpty),
        .count    (inCount)
    );

    assign interruptSignal = irqReg;
    assign devOutData      = outHead;
    assign devOutValid     = !outEmpty;
    assign devInReady      = !inFull && !reset;
    assign inPortData      = inEmpty ? '0 : inHead;
endmodule

// File: doc/io_port_unit.md
# io_port_unit

Peripheral at the far end of the processor's I/O port interface. It captures words the processor emits on `outPortData` when `outSignalEn` is high and drains them to an external device. It buffers words arriving from an external device and presents the head word on `inPortData` for the processor's IN instruction. It drives the processor's 2-bit `interruptSignal` to flag input arrival and output overrun.

## Interface
- `DEPTH`, 4: entries per FIFO; power of two, ≥2.
- `WIDTH`, `` `inPortWidth `` (16): data word width.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `outPortData` input WIDTH: word from processor (ALU result).
- `outSignalEn` input 1: processor OUT strobe; one word per high cycle.
- `inPortRead` input 1: processor consumes `inPortData` this cycle (IN instruction in decode).
- `inPortData` output WIDTH: head of input FIFO; 0 when empty.
- `interruptSignal` output 2: [0] input-arrival pulse, [1] output-overrun pulse.
- `devOutData` output WIDTH: head of output FIFO.
- `devOutValid` output 1: output FIFO non-empty.
- `devOutReady` input 1: device accepts `devOutData`.
- `devInData` input WIDTH: word from device.
- `devInValid` input 1: device offers `devInData`.
- `devInReady` output 1: input FIFO can accept.
- `outCount`, `inCount` output $clog2(DEPTH)+1: current occupancy.

## Operation
- Two independent circular FIFOs.
  - Each has read pointer, write pointer and count registers.
  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1→0.
  - Count ranges 0..DEPTH.
- Output path:
  - Push when `outSignalEn && (!outFull || pop)`.
  - Pop when `devOutValid && devOutReady`.
  - When full and popped in the same cycle, the push is accepted and count stays DEPTH.
  - `outSignalEn` while full with no pop: word dropped, pointers unchanged, overrun event raised.
- Input path:
  - `devInReady = !inFull && !reset`.
  - Push when `devInValid && devInReady`.
  - Pop when `inPortRead && !inEmpty`.
  - `inPortRead` on empty is a no-op; `inPortData` reads 0.
  - Simultaneous push and pop is legal at any occupancy except full, where `devInReady` is 0. Count is unchanged.
- `interruptSignal[0]` is a registered one-cycle pulse in the cycle after the input FIFO goes from count 0 to count 1. It does not pulse again while the FIFO stays non-empty.
- `interruptSignal[1]` is a registered one-cycle pulse in the cycle after an output word is dropped. Back-to-back drops give back-to-back pulses.
- `devOutData` and `inPortData` come combinationally from storage at the read pointer. Storage itself is not reset; the data outputs are gated by the empty flags:
  - `inPortData` = 0 when empty.
  - `devOutData` is don't-care when `devOutValid` = 0.

## Timing
- Reset, at the clock edge with `reset` high:
  - Pointers and counts cleared.
  - `interruptSignal` = 2'b00, `devOutValid` = 0, `inPortData` = 0, `outCount` = `inCount` = 0.
  - `devInReady` = 0 while `reset` is high.
  - Pushes and pops in a reset cycle are ignored.
  - Reset mid-transfer discards all buffered words with no interrupt.
- Latency:
  - A word pushed at edge N is visible on `devOutData` / `inPortData` in the cycle after edge N.
  - A pop at edge N exposes the next word after edge N.
- Full/empty flags and counts are registered-state derived and update on the same edge as the push/pop.
- Interrupt pulses are one cycle wide, one cycle after the triggering edge.
- Throughput: one push and one pop per FIFO per cycle.

## Structure
- Shared defines: `inPortWidth`, the default `DEPTH` constant, and interrupt bit indices (`IRQ_IN_ARRIVAL` = 0, `IRQ_OUT_OVERRUN` = 1). These live in the shared defines file.
- Sub-module `io_fifo` (params DEPTH, WIDTH; ports clk, reset, push, pushData, pop, headData, full, empty, count), instantiated twice.
- Top level holds the push/pop qualification, the overrun/arrival detection and the interrupt registers.

## Test plan
- Reset, then idle: all outputs at reset values; `devInReady` goes to 1 in the first cycle after `reset` falls.
- Out stream with `devOutReady` = 0: write 16'h0011, 0022, 0033, 0044, 0055 on consecutive cycles.
  - `outCount` reaches 4.
  - Fifth write dropped; `interruptSignal` = 2'b10 for exactly one cycle.
  - Raising `devOutReady` drains 0011..0044 in order.
- Full output FIFO with simultaneous pop and `outSignalEn` (16'hBEEF): no overrun pulse, count stays 4, BEEF emerges last.
- Device pushes 16'h1234 into the empty input FIFO:
  - `interruptSignal` = 2'b01 for one cycle.
  - `inPortData` = 16'h1234.
  - A second push of 16'h5678 gives no pulse.
  - `inPortRead` exposes 5678, a second read gives 0, and a third read on empty leaves count 0.
- Pointer wrap: push and pop 10 words (16'h0001..000A) through the input FIFO with simultaneous push/pop. Order is preserved and `inCount` never exceeds 4.
- Reset asserted with 3 words in each FIFO: both counts go to 0, `devOutValid` = 0, no interrupt pulses.
